instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset: synchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word-aligned fetch address; equals pc.
REQ-006 imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 instr_done  in  1  downstream stages finished the held instruction (one-cycle pulse).
REQ-009 branch  in  1  Branch from the control unit for the held instruction.
REQ-010 zero  in  1  ALU zero flag for the held instruction.
REQ-011 jump  in  1  Jump from the control unit (j and jal).
REQ-012 instr  out  32  held instruction register.
REQ-013 opcode  out  6  instr[31:26]; drives the control unit OPcode input.
REQ-014 instr_valid  out  1  instr/opcode are valid and held.
REQ-015 pc  out  32  address of the held instruction.
REQ-016 pc_plus4  out  32  pc + 4; jal link value.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-018 IDLE SHALL last exactly one cycle and then go to REQ.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL be pc.
REQ-020 In REQ with imem_ready=1, instr SHALL capture imem_rdata and the FSM SHALL go to HOLD on that edge.
REQ-021 In REQ with imem_ready=0, the FSM SHALL remain in REQ with pc and imem_addr stable.
REQ-022 In HOLD, instr_valid SHALL be 1, imem_req SHALL be 0, and instr SHALL remain stable.
REQ-023 In HOLD with instr_done=1, pc SHALL load next_pc and the FSM SHALL go to REQ.
REQ-024 instr_done SHALL be ignored in IDLE and REQ.
REQ-025 branch, zero and jump SHALL be sampled only on the HOLD-exit edge.
REQ-026 next_pc = {pc_plus4[31:28], instr[25:0], 2'b00} when jump=1.
REQ-027 Otherwise next_pc = pc_plus4 + (sign-extended instr[15:0] << 2) when branch=1 and zero=1.
REQ-028 Otherwise next_pc = pc_plus4.
REQ-029 Jump SHALL take priority over branch when both are asserted.
REQ-030 All PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, and a negative offset below 0 wraps.
REQ-031 pc[1:0] SHALL always be 2'b00; RESET_PC[1:0] SHALL be forced to 00 on load.
REQ-032 opcode and pc_plus4 SHALL be combinational from instr and pc.
REQ-033 Latency: reset release to first imem_req is 1 cycle; imem_ready to instr_valid is 1 cycle; instr_done to the next imem_req is 1 cycle.

Reset
REQ-034 With rst_n=0 at a clock edge, the following SHALL apply on that edge:
- state = IDLE, pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0.
REQ-035 Reset SHALL take effect in any state, including REQ with a pending imem_ready, which SHALL be discarded.
REQ-036 Reset SHALL take effect in HOLD even when instr_done=1 on the same edge; reset wins.
REQ-037 No output SHALL change between clock edges, except the combinational opcode and pc_plus4.

Verification
REQ-038 Sequential fetch:
- Reset, then imem_ready=1 on every request, with imem_rdata = 32'h2008_0005 (addi).
- Required: opcode = 6'b001000 and instr_valid=1.
- After instr_done, imem_addr = 32'h0000_0004.
REQ-039 Taken beq:
- pc = 32'h0000_0010, instr = 32'h1000_FFFE, branch=1, zero=1, instr_done.
- Required: next imem_addr = 32'h0000_000C.
- Same stimulus with zero=0 -> 32'h0000_0014.
REQ-040 Jump and jal:
- pc = 32'h4000_0008, instr = 32'h0C00_0100, jump=1 and branch=1.
- Required: next imem_addr = 32'h4000_0400 and pc_plus4 = 32'h4000_000C while held.
REQ-041 Memory stall:
- imem_ready=0 for 5 cycles.
- Required: imem_req=1 with a constant imem_addr and instr_valid=0 throughout.
- Capture occurs on the 6th cycle, when imem_ready=1.
REQ-042 Mid-operation reset:
- rst_n=0 while in REQ with imem_ready=1.
- Required: the next cycle has instr_valid=0 and pc = RESET_PC.
- The following request is issued from RESET_PC.
REQ-043 Wrap-around:
- pc = 32'hFFFF_FFFC, no branch or jump, instr_done.
- Required: next imem_addr = 32'h0000_0000.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch stage (master) and memory (slave).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: requests one instruction at pc, holds it until downstream signals done,
// then advances pc by sequential, taken-branch or jump target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_if.master        imem,
  input  logic                       instr_done,
  input  logic                       branch,
  input  logic                       zero,
  input  logic                       jump,
  output logic [31:0]                instr,
  output logic [5:0]                 opcode,
  output logic                       instr_valid,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] branch_off_w;
  logic [31:0] next_pc_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Control inputs only matter on the HOLD-exit edge, where next_pc_w is consumed.
  always_comb begin
    pc_plus4_w   = pc_q + 32'd4;
    branch_off_w = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump)
      next_pc_w = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    else if (branch && zero)
      next_pc_w = pc_plus4_w + branch_off_w;
    else
      next_pc_w = pc_plus4_w;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_done) begin
          pc_d    = {next_pc_w[31:2], 2'b00};
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state_q == REQ);
    imem.imem_addr = pc_q;
    instr_valid    = (state_q == HOLD);
    instr          = instr_q;
    opcode         = instr_q[31:26];
    pc             = pc_q;
    pc_plus4       = pc_plus4_w;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances, one at the default reset PC
// and one whose reset PC has nonzero low bits and sits in the 0x4xxx_xxxx region.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: RESET_PC = 0
  instruction_fetch_if bus0 ();
  logic        rst_n0, done0, branch0, zero0, jump0;
  logic [31:0] instr0, pc0, pc_plus4_0;
  logic [5:0]  opcode0;
  logic        valid0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n0),
    .imem        (bus0.master),
    .instr_done  (done0),
    .branch      (branch0),
    .zero        (zero0),
    .jump        (jump0),
    .instr       (instr0),
    .opcode      (opcode0),
    .instr_valid (valid0),
    .pc          (pc0),
    .pc_plus4    (pc_plus4_0)
  );

  // Instance 1: RESET_PC with low bits set, must load as 0x4000_0008
  instruction_fetch_if bus1 ();
  logic        rst_n1, done1, branch1, zero1, jump1;
  logic [31:0] instr1, pc1, pc_plus4_1;
  logic [5:0]  opcode1;
  logic        valid1;

  instruction_fetch #(.RESET_PC(32'h4000_000B)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n1),
    .imem        (bus1.master),
    .instr_done  (done1),
    .branch      (branch1),
    .zero        (zero1),
    .jump        (jump1),
    .instr       (instr1),
    .opcode      (opcode1),
    .instr_valid (valid1),
    .pc          (pc1),
    .pc_plus4    (pc_plus4_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word at the current REQ address of dut0, leaving it in HOLD.
  task automatic fetch0(input logic [31:0] word);
    bus0.imem_ready = 1'b1;
    bus0.imem_rdata = word;
    tick();
    bus0.imem_ready = 1'b0;
    bus0.imem_rdata = '0;
  endtask

  // Release dut0 from HOLD with the given control inputs; returns to REQ.
  task automatic retire0(input logic b, input logic z, input logic j);
    branch0 = b; zero0 = z; jump0 = j; done0 = 1'b1;
    tick();
    branch0 = 1'b0; zero0 = 1'b0; jump0 = 1'b0; done0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n0 = 1'b0;
    tick();
    tick();
    n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid0); end
    n_checks++; if (bus0.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus0.imem_req); end
    n_checks++; if (pc0 !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc0); end
    n_checks++; if (instr0 !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr0); end
    rst_n0 = 1'b1;
    tick();
    n_checks++; if (bus0.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", bus0.imem_req); end
    n_checks++; if (bus0.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 00000000", bus0.imem_addr); end
  endtask

  task automatic test_sequential();
    fetch0(32'h2008_0005);
    n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %b expected 1", valid0); end
    n_checks++; if (opcode0 !== 6'b001000) begin n_fail++; $display("FAIL seq_opcode: got %b expected 001000", opcode0); end
    n_checks++; if (instr0 !== 32'h2008_0005) begin n_fail++; $display("FAIL seq_instr: got %h expected 20080005", instr0); end
    n_checks++; if (bus0.imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_hold_req: got %b expected 0", bus0.imem_req); end
    // HOLD without done must stay put
    tick();
    n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL seq_hold_stay: got %b expected 1", valid0); end
    retire0(1'b0, 1'b0, 1'b0);
    n_checks++; if (bus0.imem_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL seq_next_addr: got %h expected 00000004", bus0.imem_addr); end
    n_checks++; if (bus0.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_next_req: got %b expected 1", bus0.imem_req); end
    n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL seq_next_valid: got %b expected 0", valid0); end
    // j 0x10 from pc 4 to set up the branch test
    fetch0(32'h0800_0004);
    retire0(1'b0, 1'b0, 1'b1);
    n_checks++; if (bus0.imem_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL j_addr: got %h expected 00000010", bus0.imem_addr); end
  endtask

  task automatic test_branch();
    // instr_done and control inputs in REQ must be ignored
    done0 = 1'b1; jump0 = 1'b1; branch0 = 1'b1; zero0 = 1'b1;
    tick();
    done0 = 1'b0; jump0 = 1'b0; branch0 = 1'b0; zero0 = 1'b0;
    n_checks++; if (bus0.imem_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL req_ignore_done: got %h expected 00000010", bus0.imem_addr); end
    n_checks++; if (bus0.imem_req !== 1'b1) begin n_fail++; $display("FAIL req_ignore_req: got %b expected 1", bus0.imem_req); end
    fetch0(32'h1000_FFFE);
    n_checks++; if (opcode0 !== 6'b000100) begin n_fail++; $display("FAIL beq_opcode: got %b expected 000100", opcode0); end
    retire0(1'b1, 1'b1, 1'b0);
    n_checks++; if (bus0.imem_addr !== 32'h0000_000C) begin n_fail++; $display("FAIL beq_taken: got %h expected 0000000C", bus0.imem_addr); end
    fetch0(32'h0000_0000);
    retire0(1'b0, 1'b0, 1'b0);
    fetch0(32'h1000_FFFE);
    retire0(1'b1, 1'b0, 1'b0);
    n_checks++; if (bus0.imem_addr !== 32'h0000_0014) begin n_fail++; $display("FAIL beq_not_taken: got %h expected 00000014", bus0.imem_addr); end
  endtask

  task automatic test_stall();
    bus0.imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0000_0014 || valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got req=%b addr=%h valid=%b expected req=1 addr=00000014 valid=0",
                 i, bus0.imem_req, bus0.imem_addr, valid0);
      end
    end
    fetch0(32'h0800_0000);
    n_checks++; if (valid0 !== 1'b1 || instr0 !== 32'h0800_0000) begin n_fail++; $display("FAIL stall_capture: got valid=%b instr=%h expected valid=1 instr=08000000", valid0, instr0); end
  endtask

  task automatic test_wrap();
    retire0(1'b0, 1'b0, 1'b1);
    n_checks++; if (bus0.imem_addr !== 32'h0) begin n_fail++; $display("FAIL j_zero: got %h expected 00000000", bus0.imem_addr); end
    // beq -2 from pc 0 lands below zero
    fetch0(32'h1000_FFFE);
    retire0(1'b1, 1'b1, 1'b0);
    n_checks++; if (bus0.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL neg_wrap: got %h expected FFFFFFFC", bus0.imem_addr); end
    fetch0(32'h0000_0000);
    n_checks++; if (pc_plus4_0 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h expected 00000000", pc_plus4_0); end
    retire0(1'b0, 1'b0, 1'b0);
    n_checks++; if (bus0.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", bus0.imem_addr); end
  endtask

  task automatic test_mid_reset();
    fetch0(32'h0000_0000);
    retire0(1'b0, 1'b0, 1'b0);
    // in REQ at pc 4 with a response pending
    rst_n0 = 1'b0;
    bus0.imem_ready = 1'b1;
    bus0.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus0.imem_ready = 1'b0;
    n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", valid0); end
    n_checks++; if (pc0 !== 32'h0) begin n_fail++; $display("FAIL rst_req_pc: got %h expected 00000000", pc0); end
    n_checks++; if (instr0 !== 32'h0) begin n_fail++; $display("FAIL rst_req_instr: got %h expected 00000000", instr0); end
    rst_n0 = 1'b1;
    tick();
    n_checks++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_refetch: got req=%b addr=%h expected req=1 addr=00000000", bus0.imem_req, bus0.imem_addr); end
    // reset beats instr_done in HOLD
    fetch0(32'h2008_0005);
    rst_n0 = 1'b0;
    done0 = 1'b1;
    tick();
    done0 = 1'b0;
    n_checks++; if (pc0 !== 32'h0 || valid0 !== 1'b0 || bus0.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got pc=%h valid=%b req=%b expected pc=00000000 valid=0 req=0", pc0, valid0, bus0.imem_req); end
    rst_n0 = 1'b1;
    tick();
    n_checks++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_hold_refetch: got req=%b addr=%h expected req=1 addr=00000000", bus0.imem_req, bus0.imem_addr); end
  endtask

  task automatic test_jump_jal();
    rst_n1 = 1'b0;
    tick();
    n_checks++; if (pc1 !== 32'h4000_0008) begin n_fail++; $display("FAIL rstpc_align: got %h expected 40000008", pc1); end
    rst_n1 = 1'b1;
    tick();
    n_checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h4000_0008) begin n_fail++; $display("FAIL jal_req: got req=%b addr=%h expected req=1 addr=40000008", bus1.imem_req, bus1.imem_addr); end
    bus1.imem_ready = 1'b1;
    bus1.imem_rdata = 32'h0C00_0100;
    tick();
    bus1.imem_ready = 1'b0;
    n_checks++; if (pc_plus4_1 !== 32'h4000_000C) begin n_fail++; $display("FAIL jal_plus4: got %h expected 4000000C", pc_plus4_1); end
    n_checks++; if (opcode1 !== 6'b000011) begin n_fail++; $display("FAIL jal_opcode: got %b expected 000011", opcode1); end
    jump1 = 1'b1; branch1 = 1'b1; zero1 = 1'b1; done1 = 1'b1;
    tick();
    jump1 = 1'b0; branch1 = 1'b0; zero1 = 1'b0; done1 = 1'b0;
    n_checks++; if (bus1.imem_addr !== 32'h4000_0400) begin n_fail++; $display("FAIL jal_target: got %h expected 40000400", bus1.imem_addr); end
  endtask

  initial begin
    rst_n0 = 1'b0; done0 = 1'b0; branch0 = 1'b0; zero0 = 1'b0; jump0 = 1'b0;
    bus0.imem_ready = 1'b0; bus0.imem_rdata = '0;
    rst_n1 = 1'b0; done1 = 1'b0; branch1 = 1'b0; zero1 = 1'b0; jump1 = 1'b0;
    bus1.imem_ready = 1'b0; bus1.imem_rdata = '0;

    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_wrap();
    test_mid_reset();
    test_jump_jal();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
